// File: rtl/decode_pkg.sv
// Shared encodings and immediate helpers for the instruction-decode stage.
package decode_pkg;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;
  localparam logic [6:0] F7Mul  = 7'b0000001;

  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3SrlSra = 3'b101;

  typedef enum logic [3:0] {
    ItOp          = 4'd0,
    ItOpImm       = 4'd1,
    ItBranch      = 4'd2,
    ItLui         = 4'd3,
    ItJal         = 4'd4,
    ItJalr        = 4'd5,
    ItLoad        = 4'd6,
    ItStore       = 4'd7,
    ItAuipc       = 4'd8,
    ItUnsupported = 4'd9
  } itype_e;

  typedef enum logic [4:0] {
    AluAdd    = 5'd0,
    AluSub    = 5'd1,
    AluAnd    = 5'd2,
    AluOr     = 5'd3,
    AluXor    = 5'd4,
    AluSlt    = 5'd5,
    AluSltu   = 5'd6,
    AluSll    = 5'd7,
    AluSrl    = 5'd8,
    AluSra    = 5'd9,
    AluMul    = 5'd10,
    AluMulh   = 5'd11,
    AluMulhsu = 5'd12,
    AluMulhu  = 5'd13,
    AluDiv    = 5'd14,
    AluDivu   = 5'd15,
    AluRem    = 5'd16,
    AluRemu   = 5'd17
  } alu_e;

  typedef enum logic [2:0] {
    BrEq  = 3'd0,
    BrNeq = 3'd1,
    BrLt  = 3'd2,
    BrLtu = 3'd3,
    BrGe  = 3'd4,
    BrGeu = 3'd5,
    BrDbr = 3'd6
  } br_e;

  typedef struct packed {
    itype_e     itype;
    alu_e       alu;
    br_e        br;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       werf;
    logic       illegal;
  } dec_t;

  function automatic logic [31:0] imm_i(input logic [31:0] i);
    return {{20{i[31]}}, i[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] i);
    return {{20{i[31]}}, i[31:25], i[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] i);
    return {i[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  // funct3 to ALU op for the base OP/OPIMM group (shift direction resolved by caller).
  function automatic alu_e alu_base(input logic [2:0] f3);
    alu_e r;
    case (f3)
      3'b000:  r = AluAdd;
      3'b001:  r = AluSll;
      3'b010:  r = AluSlt;
      3'b011:  r = AluSltu;
      3'b100:  r = AluXor;
      3'b101:  r = AluSrl;
      3'b110:  r = AluOr;
      default: r = AluAnd;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface decode_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [3:0]      out_itype;
  logic [4:0]      out_alufunc;
  logic [2:0]      out_brfunc;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic            out_werf;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_itype, out_alufunc, out_brfunc,
           out_rd, out_rs1, out_rs2, out_werf, out_imm, out_illegal
  );

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_itype, out_alufunc, out_brfunc,
           out_rd, out_rs1, out_rs2, out_werf, out_imm, out_illegal
  );
endinterface

// File: rtl/decode_comb.sv
// Purely combinational RV32I(+M) decode of one instruction word with strict field checks.
module decode_comb
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned EN_M = 0
) (
  input  logic [31:0]     inst,
  output dec_t            dec,
  output logic [XLEN-1:0] imm
);

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd_f;

  itype_e      itype;
  alu_e        alu;
  br_e         br;
  logic [31:0] imm32;
  logic        ok, use_rd, use_rs1, use_rs2;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign rd_f   = inst[11:7];

  always_comb begin
    itype   = ItUnsupported;
    alu     = AluAdd;
    br      = BrDbr;
    imm32   = '0;
    ok      = 1'b0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;

    case (opcode)
      OpcOp: begin
        itype   = ItOp;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        if (funct7 == F7Base) begin
          ok  = 1'b1;
          alu = alu_base(funct3);
        end else if (funct7 == F7Alt && (funct3 == F3AddSub || funct3 == F3SrlSra)) begin
          ok  = 1'b1;
          alu = (funct3 == F3AddSub) ? AluSub : AluSra;
        end else if (funct7 == F7Mul && EN_M != 0) begin
          ok  = 1'b1;
          alu = alu_e'(5'(AluMul) + {2'b00, funct3});
        end
      end
      OpcOpImm: begin
        itype   = ItOpImm;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        imm32   = imm_i(inst);
        if (funct3 == F3Sll) begin
          ok  = (funct7 == F7Base);
          alu = AluSll;
        end else if (funct3 == F3SrlSra) begin
          ok  = (funct7 == F7Base) || (funct7 == F7Alt);
          alu = (funct7 == F7Alt) ? AluSra : AluSrl;
        end else begin
          ok  = 1'b1;
          alu = alu_base(funct3);
        end
      end
      OpcBranch: begin
        itype   = ItBranch;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = imm_b(inst);
        ok      = 1'b1;
        case (funct3)
          3'b000:  br = BrEq;
          3'b001:  br = BrNeq;
          3'b100:  br = BrLt;
          3'b101:  br = BrGe;
          3'b110:  br = BrLtu;
          3'b111:  br = BrGeu;
          default: ok = 1'b0;
        endcase
      end
      OpcLui, OpcAuipc: begin
        itype  = (opcode == OpcLui) ? ItLui : ItAuipc;
        use_rd = 1'b1;
        imm32  = imm_u(inst);
        ok     = 1'b1;
      end
      OpcJal: begin
        itype  = ItJal;
        use_rd = 1'b1;
        imm32  = imm_j(inst);
        ok     = 1'b1;
      end
      OpcJalr: begin
        itype   = ItJalr;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        imm32   = imm_i(inst);
        ok      = (funct3 == 3'b000);
      end
      OpcLoad: begin
        itype   = ItLoad;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        imm32   = imm_i(inst);
        ok      = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end
      OpcStore: begin
        itype   = ItStore;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = imm_s(inst);
        ok      = (funct3 <= 3'b010);
      end
      default: ok = 1'b0;
    endcase

    // Rejected encodings collapse to a fully neutral Unsupported record.
    if (!ok) begin
      itype   = ItUnsupported;
      alu     = AluAdd;
      br      = BrDbr;
      imm32   = '0;
      use_rd  = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
    end
  end

  always_comb begin
    dec.itype   = itype;
    dec.alu     = alu;
    dec.br      = br;
    dec.rd      = use_rd ? rd_f : 5'd0;
    dec.rs1     = use_rs1 ? inst[19:15] : 5'd0;
    dec.rs2     = use_rs2 ? inst[24:20] : 5'd0;
    dec.werf    = use_rd && (rd_f != 5'd0);
    dec.illegal = (itype == ItUnsupported);
    imm         = XLEN'($signed(imm32));
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: combinational decode into a 2-entry skid buffer, with a RAW scoreboard
// that holds issue until writeback clears the sources.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned EN_M  = 0,
  parameter int unsigned EN_SB = 1
) (
  input  logic       clk,
  input  logic       rst,
  decode_if.slave    bus,
  input  logic       flush,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    dec_t            dec;
  } entry_t;

  dec_t            in_dec;
  logic [XLEN-1:0] in_imm;
  entry_t          in_entry;

  entry_t      a_q, a_d, b_q, b_d;
  logic        a_valid_q, a_valid_d, b_valid_q, b_valid_d;
  logic        in_ready_q;
  logic [31:0] busy_q, busy_d, wb_clr, busy_eff;
  logic        hazard, out_valid, issue, accept;

  decode_comb #(
    .XLEN (XLEN),
    .EN_M (EN_M)
  ) u_comb (
    .inst (bus.in_inst),
    .dec  (in_dec),
    .imm  (in_imm)
  );

  always_comb begin
    in_entry.pc  = bus.in_pc;
    in_entry.imm = in_imm;
    in_entry.dec = in_dec;
  end

  always_comb begin
    wb_clr = '0;
    if (wb_valid) wb_clr[wb_rd] = 1'b1;
    // A retiring write this cycle already counts as free for the hazard check.
    busy_eff = busy_q & ~wb_clr;

    hazard = 1'b0;
    if (EN_SB != 0) hazard = a_valid_q & (busy_eff[a_q.dec.rs1] | busy_eff[a_q.dec.rs2]);
    out_valid = a_valid_q & ~hazard;
    issue     = out_valid & bus.out_ready;
    accept    = bus.in_valid & in_ready_q & ~flush;

    a_d       = a_q;
    b_d       = b_q;
    a_valid_d = a_valid_q;
    b_valid_d = b_valid_q;
    if (!a_valid_q || issue) begin
      if (b_valid_q) begin
        a_d       = b_q;
        a_valid_d = 1'b1;
        b_valid_d = 1'b0;
        if (accept) begin
          b_d       = in_entry;
          b_valid_d = 1'b1;
        end
      end else if (accept) begin
        a_d       = in_entry;
        a_valid_d = 1'b1;
      end else begin
        a_valid_d = 1'b0;
      end
    end else if (accept) begin
      b_d       = in_entry;
      b_valid_d = 1'b1;
    end
    if (flush) begin
      a_valid_d = 1'b0;
      b_valid_d = 1'b0;
    end

    // Set is applied after the clear so a same-register set/clear leaves it busy.
    busy_d = busy_q & ~wb_clr;
    if (issue && a_q.dec.werf) busy_d[a_q.dec.rd] = 1'b1;
    busy_d[0] = 1'b0;
    if (EN_SB == 0) busy_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      a_valid_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      in_ready_q <= 1'b1;
      busy_q     <= '0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      a_valid_q  <= a_valid_d;
      b_valid_q  <= b_valid_d;
      in_ready_q <= ~b_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid;
  assign bus.out_pc      = a_q.pc;
  assign bus.out_itype   = a_q.dec.itype;
  assign bus.out_alufunc = a_q.dec.alu;
  assign bus.out_brfunc  = a_q.dec.br;
  assign bus.out_rd      = a_q.dec.rd;
  assign bus.out_rs1     = a_q.dec.rs1;
  assign bus.out_rs2     = a_q.dec.rs2;
  assign bus.out_werf    = a_q.dec.werf;
  assign bus.out_imm     = a_q.imm;
  assign bus.out_illegal = a_q.dec.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vector table plus hazard, backpressure and flush runs.
module tb_decode_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       wb_valid;
  logic [4:0] wb_rd;

  int checks = 0;
  int errors = 0;

  logic [63:0] issued[$];

  decode_if #(.XLEN(32)) bus ();
  decode_if #(.XLEN(32)) bus_m ();

  assign bus_m.in_valid  = bus.in_valid;
  assign bus_m.in_inst   = bus.in_inst;
  assign bus_m.in_pc     = bus.in_pc;
  assign bus_m.out_ready = bus.out_ready;

  decode_stage #(.XLEN(32), .EN_M(0), .EN_SB(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .flush    (flush),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd)
  );

  decode_stage #(.XLEN(32), .EN_M(1), .EN_SB(1)) dut_m (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_m),
    .flush    (flush),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) issued.push_back(64'(bus.out_pc));
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  itype;
    logic [4:0]  alu;
    logic [2:0]  br;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        werf;
    logic [31:0] imm;
    logic        ill;
    logic [3:0]  m_itype;
    logic [4:0]  m_alu;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{32'h002081B3, 4'd0, 5'd0, 3'd6, 5'd3, 5'd1, 5'd2, 1'b1, 32'h0, 1'b0, 4'd0, 5'd0};
    vecs[1]  = '{32'hFFF00093, 4'd1, 5'd0, 3'd6, 5'd1, 5'd0, 5'd0, 1'b1, 32'hFFFFFFFF, 1'b0,
                 4'd1, 5'd0};
    vecs[2]  = '{32'h0000007F, 4'd9, 5'd0, 3'd6, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b1, 4'd9, 5'd0};
    vecs[3]  = '{32'h402081B3, 4'd0, 5'd1, 3'd6, 5'd3, 5'd1, 5'd2, 1'b1, 32'h0, 1'b0, 4'd0, 5'd1};
    vecs[4]  = '{32'h422081B3, 4'd9, 5'd0, 3'd6, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b1, 4'd9, 5'd0};
    vecs[5]  = '{32'h022081B3, 4'd9, 5'd0, 3'd6, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b1, 4'd0, 5'd10};
    vecs[6]  = '{32'h00000013, 4'd1, 5'd0, 3'd6, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 4'd1, 5'd0};
    vecs[7]  = '{32'hFE208EE3, 4'd2, 5'd0, 3'd0, 5'd0, 5'd1, 5'd2, 1'b0, 32'hFFFFFFFC, 1'b0,
                 4'd2, 5'd0};
    vecs[8]  = '{32'h123452B7, 4'd3, 5'd0, 3'd6, 5'd5, 5'd0, 5'd0, 1'b1, 32'h12345000, 1'b0,
                 4'd3, 5'd0};
    vecs[9]  = '{32'h000090E7, 4'd9, 5'd0, 3'd6, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b1, 4'd9, 5'd0};
    vecs[10] = '{32'h0020A423, 4'd7, 5'd0, 3'd6, 5'd0, 5'd1, 5'd2, 1'b0, 32'h8, 1'b0, 4'd7, 5'd0};
    vecs[11] = '{32'h4030D213, 4'd1, 5'd9, 3'd6, 5'd4, 5'd1, 5'd0, 1'b1, 32'h403, 1'b0, 4'd1, 5'd9};
    vecs[12] = '{32'h0000B083, 4'd9, 5'd0, 3'd6, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b1, 4'd9, 5'd0};
    vecs[13] = '{32'h008000EF, 4'd4, 5'd0, 3'd6, 5'd1, 5'd0, 5'd0, 1'b1, 32'h8, 1'b0, 4'd4, 5'd0};

    rst           = 1'b1;
    flush         = 1'b0;
    wb_valid      = 1'b0;
    wb_rd         = 5'd0;
    bus.in_valid  = 1'b0;
    bus.in_inst   = 32'h0;
    bus.in_pc     = 32'h0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset out_illegal", 64'(bus.out_illegal), 64'd0);
    chk("reset out_pc", 64'(bus.out_pc), 64'd0);
    chk("reset out_itype", 64'(bus.out_itype), 64'd0);

    // Decode table: one instruction at a time, destination retired afterwards.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      wb_valid     = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_inst  = vecs[i].inst;
      bus.in_pc    = 32'h1000 + 32'(i * 4);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      chk($sformatf("v%0d out_valid", i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("v%0d pc", i), 64'(bus.out_pc), 64'(32'h1000 + 32'(i * 4)));
      chk($sformatf("v%0d itype", i), 64'(bus.out_itype), 64'(vecs[i].itype));
      chk($sformatf("v%0d alu", i), 64'(bus.out_alufunc), 64'(vecs[i].alu));
      chk($sformatf("v%0d br", i), 64'(bus.out_brfunc), 64'(vecs[i].br));
      chk($sformatf("v%0d rd", i), 64'(bus.out_rd), 64'(vecs[i].rd));
      chk($sformatf("v%0d rs1", i), 64'(bus.out_rs1), 64'(vecs[i].rs1));
      chk($sformatf("v%0d rs2", i), 64'(bus.out_rs2), 64'(vecs[i].rs2));
      chk($sformatf("v%0d werf", i), 64'(bus.out_werf), 64'(vecs[i].werf));
      chk($sformatf("v%0d imm", i), 64'(bus.out_imm), 64'(vecs[i].imm));
      chk($sformatf("v%0d illegal", i), 64'(bus.out_illegal), 64'(vecs[i].ill));
      chk($sformatf("v%0d m itype", i), 64'(bus_m.out_itype), 64'(vecs[i].m_itype));
      chk($sformatf("v%0d m alu", i), 64'(bus_m.out_alufunc), 64'(vecs[i].m_alu));
      @(negedge clk);
      wb_valid = 1'b1;
      wb_rd    = vecs[i].inst[11:7];
    end
    @(negedge clk);
    wb_valid = 1'b0;

    // RAW hazard: add x3,x1,x2 waits for writeback of x1 and issues in that cycle.
    issued.delete();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_inst  = 32'h00100093;
    bus.in_pc    = 32'h200;
    @(negedge clk);
    bus.in_inst = 32'h002081B3;
    bus.in_pc   = 32'h204;
    #1;
    chk("haz addi valid", 64'(bus.out_valid), 64'd1);
    chk("haz addi pc", 64'(bus.out_pc), 64'h200);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("haz stall valid", 64'(bus.out_valid), 64'd0);
    chk("haz stall pc", 64'(bus.out_pc), 64'h204);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("haz hold %0d", k), 64'(bus.out_valid), 64'd0);
    end
    @(negedge clk);
    wb_valid = 1'b1;
    wb_rd    = 5'd1;
    #1;
    chk("haz wb bypass valid", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    wb_valid = 1'b0;
    #1;
    chk("haz drained", 64'(bus.out_valid), 64'd0);
    chk("haz issue count", 64'(issued.size()), 64'd2);
    if (issued.size() == 2) chk("haz issue order", issued[1], 64'h204);
    @(negedge clk);
    wb_valid = 1'b1;
    wb_rd    = 5'd3;
    @(negedge clk);
    wb_valid = 1'b0;

    // Backpressure: three pushes against a stalled consumer.
    issued.delete();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_inst   = 32'h00000013;
    bus.in_pc     = 32'h300;
    #1;
    chk("bp rdy first", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_pc = 32'h304;
    #1;
    chk("bp rdy second", 64'(bus.in_ready), 64'd1);
    chk("bp A valid", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    bus.in_pc = 32'h308;
    #1;
    chk("bp rdy low", 64'(bus.in_ready), 64'd0);
    chk("bp pc held", 64'(bus.out_pc), 64'h300);
    @(negedge clk);
    #1;
    chk("bp rdy still low", 64'(bus.in_ready), 64'd0);
    chk("bp pc stable", 64'(bus.out_pc), 64'h300);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp rdy back", 64'(bus.in_ready), 64'd1);
    chk("bp pc second", 64'(bus.out_pc), 64'h304);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("bp pc third", 64'(bus.out_pc), 64'h308);
    repeat (2) @(negedge clk);
    chk("bp issue count", 64'(issued.size()), 64'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < issued.size()) chk($sformatf("bp order %0d", k), issued[k], 64'(32'h300 + 4 * k));
    end

    // Flush with A and B occupied and a third instruction offered.
    issued.delete();
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_pc    = 32'h400;
    @(negedge clk);
    bus.in_pc = 32'h404;
    @(negedge clk);
    bus.in_pc = 32'h408;
    flush     = 1'b1;
    #1;
    chk("fl pre valid", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("fl out_valid", 64'(bus.out_valid), 64'd0);
    chk("fl in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("fl none issued", 64'(issued.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined, parametrised instruction-decode stage between fetch and execute. Decodes RV32I (optionally RV32M) into the core's iType/aluFunc/brFunc/immediate encoding. Holds results in a 2-entry valid/ready skid buffer and stalls issue on read-after-write hazards using a 32-entry register scoreboard cleared by writeback. Strict field checking flags illegal instructions instead of silently aliasing them.

## Interface
Parameters:
- XLEN, 32: datapath width, 32 or 64; immediates and PC are sign-extended to XLEN.
- EN_M, 0: 1 enables M-extension decode; 0 makes funct7=0000001 OP instructions illegal.
- EN_SB, 1: 1 enables the scoreboard; 0 makes the hazard signal constant 0.

Ports (reset is synchronous and active-high, single clock):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  fetch holds a valid instruction
- in_ready  out  1  stage can accept; registered
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction address
- flush  in  1  drop all buffered instructions
- wb_valid  in  1  writeback retiring a register write
- wb_rd  in  5  writeback destination
- out_valid  out  1  decoded instruction available and hazard-free
- out_ready  in  1  execute accepts
- out_pc  out  XLEN  passthrough PC
- out_itype  out  4  OP=0, OPIMM=1, BRANCH=2, LUI=3, JAL=4, JALR=5, LOAD=6, STORE=7, AUIPC=8, Unsupported=9
- out_alufunc  out  5  Add=0 Sub=1 And=2 Or=3 Xor=4 Slt=5 Sltu=6 Sll=7 Srl=8 Sra=9 Mul=10 Mulh=11 Mulhsu=12 Mulhu=13 Div=14 Divu=15 Rem=16 Remu=17
- out_brfunc  out  3  Eq=0 Neq=1 Lt=2 Ltu=3 Ge=4 Geu=5 Dbr=6
- out_rd, out_rs1, out_rs2  out  5  register indices; unused sources are 0
- out_werf  out  1  register-file write enable
- out_imm  out  XLEN  sign-extended immediate (I/S/B/U/J per type), 0 for OP
- out_illegal  out  1  set when out_itype=Unsupported

## Operation
- Decode rules: opcodes, funct3 values and immediate formats are the standard RV32I ones. Unused fields give rd/rs=0, brfunc=Dbr, alufunc=Add.
- Strict funct7 checking:
  - OP: funct7 0000000 or 0100000 (the latter only for ADD/SUB and SRL/SRA); 0000001 only when EN_M=1.
  - OPIMM shifts: funct7 0000000, or 0100000 for SRAI.
  - Anything else → Unsupported.
- Other Unsupported cases: JALR with funct3≠000, branch funct3 010/011, load funct3 011/110/111, store funct3 ≥011, unknown opcode.
- An Unsupported instruction has werf=0, rd=rs1=rs2=0, imm=0, illegal=1.
- werf is forced 0 when rd=0.
- Buffer: entry A drives the outputs; entry B is the skid entry. An accept (in_valid&in_ready) fills A if A is empty or issuing this cycle, otherwise B. When A issues, B moves to A. in_ready next cycle = B empty after this cycle's update.
- Hazard = A valid & (busy[out_rs1] | busy[out_rs2]) after same-cycle clear. Index 0 is never busy.
- out_valid = A valid & !hazard. Issue = out_valid & out_ready.
- Scoreboard update:
  - Issue with out_werf sets busy[out_rd].
  - wb_valid clears busy[wb_rd].
  - Same register set and cleared in one cycle → set wins.
  - A wb clear in the same cycle as the hazard check counts as not busy (combinational bypass).
- Flush: A and B invalidated next cycle; the same-cycle in_valid is discarded. Issue is still allowed in the flush cycle (that instruction is older). The scoreboard is not altered.
- Reset: A/B invalid, all payload registers 0, busy vector 0, in_ready=1 from the first cycle after reset, out_valid=0, out_illegal=0.

## Timing
- Latency: accept in cycle N → out_valid in N+1 (no hazard).
- Throughput: 1 instruction/cycle with out_ready held high.
- Outputs are registered except out_valid, which gates the registered A-valid with the combinational hazard.
- out_* payload holds stable while out_valid=1 & out_ready=0, and also during hazard stalls.
- in_ready falls one cycle after B fills and rises the cycle after B drains. No instruction is lost or reordered.
- A stalled instruction issues in the same cycle as the wb_valid that clears its source.

## Structure
- Package decode_pkg: opcode and funct3/funct7 constants, iType/aluFunc/brFunc encodings, immediate-format helper functions.
- Sub-module decode_comb: purely combinational decode of one instruction, parametrised by XLEN/EN_M. decode_stage instantiates it on in_inst and adds the buffer and scoreboard.

## Test plan
- 0x002081B3 (add x3,x1,x2), then 0xFFF00093 (addi x1,x0,-1) → itype 0/alu 0/rd 3/rs1 1/rs2 2/werf 1; then itype 1/imm 0xFFFFFFFF/rs1 0/rs2 0 (XLEN=64: imm all ones).
- addi x1 issued, then add x3,x1,x2 → out_valid held 0 until wb_valid with wb_rd=1, then out_valid=1 in that same cycle.
- out_ready=0 for 3 cycles, push 3 instructions → in_ready low after the 2nd. Release out_ready → 3 issues in order, no loss.
- flush with A and B full plus in_valid=1 → out_valid=0 next cycle, in_ready=1, none of the three flushed instructions issues.
- 0x0000007F, 0x402081B3 (sub, ok), 0x422081B3 (bad funct7) → illegal=1/itype 9/werf 0; alu 1; illegal=1.
- 0x022081B3 (mul): EN_M=1 → alu 10; EN_M=0 → itype 9. 0x00000013 (addi x0) → werf 0.
